// File: rtl/alu_issue_stage.sv
// Operand fetch, issue and writeback for the registered 16-bit ALU; optional MUL_HI_WB_EN adds MUL high-half writeback.
// Latency: ALU ops 3 cycles accept-to-idle (writeback at E2); LDI/NOP/illegal 2 cycles.
// Backpressure: instr_ready is high only in IDLE, so one instruction is in flight at a time.
module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        operations,
    input  logic [DATA_W-1:0] alu_out_16,
    input  logic [31:0]       alu_out,
    output logic              wb_valid,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       retire_cnt,
    output logic              div0_err,
    output logic              illegal_err,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_LDI = 4'd11;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] regs [NREG];
    logic [3:0]        op_q;
    logic [2:0]        rd_q;
    logic [DATA_W-1:0] imm_q;
    logic              div0_q;

    logic [3:0] in_op;
    logic [2:0] in_rd, in_rs, in_rt;
    logic       in_is_alu;
    logic       accept;
    logic       wb_is_alu;
    logic [DATA_W-1:0] alu_res;

    assign in_op     = instr[15:12];
    assign in_rd     = instr[11:9];
    assign in_rs     = instr[8:6];
    assign in_rt     = instr[5:3];
    assign in_is_alu = (in_op != OP_NOP) && (in_op <= OP_ROL);
    assign accept    = instr_valid && instr_ready;
    assign wb_is_alu = (op_q != OP_NOP) && (op_q <= OP_ROL);
    assign alu_res   = (op_q == OP_MUL) ? alu_out[DATA_W-1:0] : alu_out_16;

    assign instr_ready = (state_q == IDLE);
    assign dbg_data    = regs[dbg_addr];

`ifdef MUL_HI_WB_EN
    logic [2:0] rd_hi;
    assign rd_hi = rd_q + 3'd1;
`else
    logic unused_mul_hi;
    assign unused_mul_hi = ^alu_out[31:DATA_W];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = in_is_alu ? EXEC : WB;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            div0_q      <= 1'b0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            operations  <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            retire_cnt  <= '0;
            div0_err    <= 1'b0;
            illegal_err <= 1'b0;
        end else begin
            wb_valid <= 1'b0;

            if (accept) begin
                op_q   <= in_op;
                rd_q   <= in_rd;
                imm_q  <= {{(DATA_W-9){instr[8]}}, instr[8:0]};
                // Divisor is judged on the value captured at issue, not at writeback.
                div0_q <= (in_op == OP_DIV) && (regs[in_rt] == '0);
                if (in_is_alu) begin
                    alu_in1    <= regs[in_rs];
                    alu_in2    <= regs[in_rt];
                    operations <= in_op;
                end
                if (in_op > OP_LDI) illegal_err <= 1'b1;
            end

            if (state_q == WB) begin
                operations <= '0;
                retire_cnt <= retire_cnt + 16'd1;
                if (op_q == OP_LDI) begin
                    regs[rd_q] <= imm_q;
                    wb_valid   <= 1'b1;
                    wb_addr    <= rd_q;
                    wb_data    <= imm_q;
                end else if (wb_is_alu) begin
                    if (op_q == OP_DIV && div0_q) begin
                        div0_err <= 1'b1;
                    end else begin
                        regs[rd_q] <= alu_res;
                        wb_valid   <= 1'b1;
                        wb_addr    <= rd_q;
                        wb_data    <= alu_res;
`ifdef MUL_HI_WB_EN
                        if (op_q == OP_MUL) regs[rd_hi] <= alu_out[31:DATA_W];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small registered ALU model on the operand side.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] alu_in1, alu_in2;
    logic [3:0]  operations;
    logic [15:0] alu_out_16 = '0;
    logic [31:0] alu_out = '0;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] retire_cnt;
    logic        div0_err, illegal_err;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    alu_issue_stage #(.DATA_W(16), .NREG(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .operations(operations), .alu_out_16(alu_out_16), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .retire_cnt(retire_cnt), .div0_err(div0_err), .illegal_err(illegal_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Registered ALU: samples operands on each rising edge.
    logic signed [31:0] prod;
    assign prod = $signed(alu_in1) * $signed(alu_in2);
    always @(posedge clk) begin
        alu_out <= prod;
        case (operations)
            4'd1: alu_out_16 <= alu_in1 + alu_in2;
            4'd2: alu_out_16 <= alu_in1 - alu_in2;
            4'd3: alu_out_16 <= prod[15:0];
            4'd4: alu_out_16 <= (alu_in2 == 0) ? 16'h0 : 16'($signed(alu_in1) / $signed(alu_in2));
            4'd5: alu_out_16 <= alu_in1 & alu_in2;
            4'd6: alu_out_16 <= alu_in1 | alu_in2;
            4'd7: alu_out_16 <= ~(alu_in1 | alu_in2);
            4'd8: alu_out_16 <= alu_in1 ^ alu_in2;
            default: alu_out_16 <= 16'h0;
        endcase
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'hB, rd, imm};
    endfunction

    // Issues one instruction and waits until the stage is idle again.
    task automatic run_instr(input logic [15:0] w, output int cycles, output bit saw_wb);
        int waits;
        saw_wb = 1'b0;
        cycles = 0;
        waits  = 0;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        exp_ret++;
        cycles = 1;
        while (!instr_ready && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (wb_valid) saw_wb = 1'b1;
        end
        checks++;
        if (!instr_ready) begin
            errors++;
            $display("FAIL timeout instr=%h: instr_ready=%b required 1", w, instr_ready);
        end
    endtask

    task automatic test_reset;
        int cyc;
        bit sw;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        run_instr(ldi(3'd4, 9'h0AA), cyc, sw);
        dbg_addr = 3'd4;
        #1;
        checks++;
        if (dbg_data !== 16'h00AA) begin errors++; $display("FAIL reset_pre_r4: got %h want 00aa", dbg_data); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dbg_data !== 16'h0000) begin errors++; $display("FAIL reset_r4: got %h want 0000", dbg_data); end
        checks++;
        if (retire_cnt !== 16'h0) begin errors++; $display("FAIL reset_retire: got %h want 0", retire_cnt); end
        checks++;
        if ({alu_in1, alu_in2, operations, wb_valid, wb_addr, wb_data, div0_err, illegal_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: in1=%h in2=%h op=%h wbv=%b wba=%h wbd=%h d0=%b ill=%b want all 0",
                     alu_in1, alu_in2, operations, wb_valid, wb_addr, wb_data, div0_err, illegal_err);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_ldi_add;
        int cyc;
        bit sw;
        run_instr(ldi(3'd1, 9'h034), cyc, sw);
        checks++;
        if (cyc != 2 || !sw) begin errors++; $display("FAIL ldi_latency: cycles=%0d wb=%b want 2/1", cyc, sw); end
        run_instr(ldi(3'd2, 9'h06A), cyc, sw);
        @(negedge clk);
        instr = enc(4'd1, 3'd3, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        exp_ret++;
        checks++;
        if (instr_ready !== 1'b0 || operations !== 4'd1 || alu_in1 !== 16'h0034 || alu_in2 !== 16'h006A) begin
            errors++;
            $display("FAIL add_issue: rdy=%b op=%h in1=%h in2=%h want 0/1/0034/006a",
                     instr_ready, operations, alu_in1, alu_in2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_e1_wbv: got %b want 0", wb_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 3'd3 || wb_data !== 16'h009E) begin
            errors++;
            $display("FAIL add_e2_wb: v=%b a=%0d d=%h want 1/3/009e", wb_valid, wb_addr, wb_data);
        end
        checks++;
        if (instr_ready !== 1'b1 || operations !== 4'd0 || retire_cnt !== 16'd3) begin
            errors++;
            $display("FAIL add_e2_state: rdy=%b op=%h ret=%0d want 1/0/3", instr_ready, operations, retire_cnt);
        end
        dbg_addr = 3'd3;
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || dbg_data !== 16'h009E) begin
            errors++;
            $display("FAIL add_e3: wbv=%b r3=%h want 0/009e", wb_valid, dbg_data);
        end
    endtask

    task automatic test_mul;
        int cyc;
        bit sw;
        logic [15:0] exp_r7, exp_r0;
`ifdef MUL_HI_WB_EN
        exp_r7 = 16'hFFFF;
        exp_r0 = 16'hFFFF;
`else
        exp_r7 = 16'h0055;
        exp_r0 = 16'h0000;
`endif
        run_instr(ldi(3'd7, 9'h055), cyc, sw);
        run_instr(ldi(3'd1, 9'h1FE), cyc, sw);
        run_instr(ldi(3'd2, 9'h003), cyc, sw);
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 16'hFFFE) begin errors++; $display("FAIL ldi_sext: got %h want fffe", dbg_data); end
        run_instr(enc(4'd3, 3'd6, 3'd1, 3'd2), cyc, sw);
        checks++;
        if (cyc != 3 || wb_addr !== 3'd6 || wb_data !== 16'hFFFA) begin
            errors++;
            $display("FAIL mul_wb: cycles=%0d a=%0d d=%h want 3/6/fffa", cyc, wb_addr, wb_data);
        end
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 16'hFFFA) begin errors++; $display("FAIL mul_r6: got %h want fffa", dbg_data); end
        dbg_addr = 3'd7;
        #1;
        checks++;
        if (dbg_data !== exp_r7) begin errors++; $display("FAIL mul_r7_hi: got %h want %h", dbg_data, exp_r7); end
        run_instr(enc(4'd3, 3'd7, 3'd1, 3'd2), cyc, sw);
        #1;
        checks++;
        if (dbg_data !== 16'hFFFA) begin errors++; $display("FAIL mul_rd7_lo: got %h want fffa", dbg_data); end
        dbg_addr = 3'd0;
        #1;
        checks++;
        if (dbg_data !== exp_r0) begin errors++; $display("FAIL mul_rd7_wrap: r0 got %h want %h", dbg_data, exp_r0); end
    endtask

    task automatic test_div0;
        int cyc;
        bit sw;
        run_instr(ldi(3'd0, 9'h000), cyc, sw);
        run_instr(enc(4'd4, 3'd3, 3'd1, 3'd0), cyc, sw);
        checks++;
        if (sw !== 1'b0 || div0_err !== 1'b1) begin
            errors++;
            $display("FAIL div0: wb=%b div0_err=%b want 0/1", sw, div0_err);
        end
        dbg_addr = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 16'h009E) begin errors++; $display("FAIL div0_r3: got %h want 009e", dbg_data); end
        checks++;
        if (retire_cnt !== 16'(exp_ret)) begin errors++; $display("FAIL div0_retire: got %0d want %0d", retire_cnt, exp_ret); end
        run_instr(ldi(3'd5, 9'h001), cyc, sw);
        checks++;
        if (div0_err !== 1'b1) begin errors++; $display("FAIL div0_sticky: got %b want 1", div0_err); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int idx;
        bit sw;
        bit acc;
        logic [15:0] q [3];
        run_instr(ldi(3'd1, 9'h005), cyc, sw);
        run_instr(ldi(3'd2, 9'h007), cyc, sw);
        q[0] = enc(4'd1, 3'd3, 3'd1, 3'd2);
        q[1] = enc(4'd1, 3'd4, 3'd3, 3'd3);
        q[2] = enc(4'd1, 3'd5, 3'd4, 3'd1);
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (instr_ready !== ((c % 3) == 0)) begin
                errors++;
                $display("FAIL bp_ready cycle %0d: got %b want %b", c, instr_ready, (c % 3) == 0);
            end
            if (idx >= 3) instr_valid = 1'b0;
            else if (instr_ready) begin
                instr = q[idx];
                instr_valid = 1'b1;
            end
            acc = instr_ready && instr_valid;
            @(posedge clk);
            if (acc) begin
                idx++;
                exp_ret++;
            end
        end
        #1;
        instr_valid = 1'b0;
        checks++;
        if (retire_cnt !== 16'(exp_ret)) begin errors++; $display("FAIL bp_retire: got %0d want %0d", retire_cnt, exp_ret); end
        dbg_addr = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 16'h001D) begin errors++; $display("FAIL bp_r5: got %h want 001d", dbg_data); end
        run_instr({4'hC, 3'd1, 9'h0}, cyc, sw);
        checks++;
        if (illegal_err !== 1'b1 || sw !== 1'b0 || cyc != 2) begin
            errors++;
            $display("FAIL illegal: err=%b wb=%b cycles=%0d want 1/0/2", illegal_err, sw, cyc);
        end
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 16'h0005 || retire_cnt !== 16'(exp_ret)) begin
            errors++;
            $display("FAIL illegal_nowrite: r1=%h ret=%0d want 0005/%0d", dbg_data, retire_cnt, exp_ret);
        end
    endtask

    task automatic test_reset_exec;
        bit sw;
        @(negedge clk);
        instr = enc(4'd1, 3'd6, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        checks++;
        if (operations !== 4'd1 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rexec_issue: op=%h rdy=%b want 1/0", operations, instr_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (retire_cnt !== 16'h0 || operations !== 4'h0 || div0_err !== 1'b0 || illegal_err !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rexec_async: ret=%0d op=%h d0=%b ill=%b rdy=%b want 0/0/0/0/1",
                     retire_cnt, operations, div0_err, illegal_err, instr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        sw = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (wb_valid) sw = 1'b1;
        end
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (sw !== 1'b0 || dbg_data !== 16'h0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rexec_drop: wb=%b r6=%h rdy=%b want 0/0000/1", sw, dbg_data, instr_ready);
        end
    endtask

    initial begin
        test_reset;
        test_ldi_add;
        test_mul;
        test_div0;
        test_back_to_back;
        test_reset_exec;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
